spec_hc_addsub_vl: RTL and testbench

//  Variable-latency wrapper that consumes a speculative carry network: adds or subtracts
//  two WIDTH-bit operands behind valid/ready handshakes. The speculative sum is

---
 rtl/spec_hc_pkg.sv | 30 +++
 rtl/spec_hc_core.sv | 65 ++++++
 rtl/spec_hc_addsub_vl.sv | 122 ++++++++++++
 tb/tb_spec_hc_addsub_vl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_hc_pkg.sv
// Shared types and the windowed-carry helper for the speculative add/sub unit.
package spec_hc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int SPEC_WIN_DEF = 8;
  localparam int WIN_MAX      = 64;

  // Carry into bit i seen by a window of at most 'win' bits below it; cin only reaches
  // bits close enough to the LSB that the window still covers bit 0.
  function automatic logic win_carry(input logic [WIN_MAX-1:0] p,
                                     input logic [WIN_MAX-1:0] g,
                                     input logic               cin,
                                     input int                 i,
                                     input int                 win);
    logic c;
    int   lo;
    lo = (i > win) ? i - win : 0;
    c  = (i <= win) ? cin : 1'b0;
    for (int j = 0; j < WIN_MAX; j++) begin
      if (j >= lo && j < i) c = g[j] | (p[j] & c);
    end
    return c;
  endfunction

endpackage

// File: rtl/spec_hc_core.sv
// Combinational carry network: windowed speculative prefix alongside a full exact prefix.
module spec_hc_core
  import spec_hc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SPEC_WIN = SPEC_WIN_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_eff,
  input  logic             cin_eff,
  output logic [WIDTH-1:0] spec_sum,
  output logic             spec_cout,
  output logic [WIDTH-1:0] exact_sum,
  output logic             exact_cout,
  output logic [WIDTH:0]   spec_c,
  output logic [WIDTH:0]   exact_c,
  output logic             err
);

  logic [WIDTH-1:0]   p, g;
  logic [WIN_MAX-1:0] p_w, g_w;
  logic [WIDTH-1:0]   gk, pk, gn, pn;

  assign p = a ^ b_eff;
  assign g = a & b_eff;

  always_comb begin
    p_w = '0;
    g_w = '0;
    p_w[WIDTH-1:0] = p;
    g_w[WIDTH-1:0] = g;
    spec_c    = '0;
    spec_c[0] = cin_eff;
    for (int i = 1; i <= WIDTH; i++) begin
      spec_c[i] = win_carry(p_w, g_w, cin_eff, i, SPEC_WIN);
    end
  end

  // Full log-depth prefix; cin is folded into bit 0's generate.
  always_comb begin
    gk    = g;
    pk    = p;
    gk[0] = g[0] | (p[0] & cin_eff);
    gn    = gk;
    pn    = pk;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int j = d; j < WIDTH; j++) begin
        gn[j] = gk[j] | (pk[j] & gk[j-d]);
        pn[j] = pk[j] & pk[j-d];
      end
      gk = gn;
      pk = pn;
    end
    exact_c = {gk, cin_eff};
  end

  assign spec_sum   = p ^ spec_c[WIDTH-1:0];
  assign spec_cout  = spec_c[WIDTH];
  assign exact_sum  = p ^ exact_c[WIDTH-1:0];
  assign exact_cout = exact_c[WIDTH];
  assign err        = ({spec_cout, spec_sum} != {exact_cout, exact_sum});

endmodule

// File: rtl/spec_hc_addsub_vl.sv
// Variable-latency add/sub wrapper around spec_hc_core with valid/ready on both sides.
// Optional saturating mis-speculation counter enabled by SPEC_HC_ERR_CNT_EN.
//
//   state | meaning
//   IDLE  | no operands held, ready to accept
//   EVAL  | operands held; speculative result offered unless it is wrong
//   FIX   | exact result offered after a mis-speculation
module spec_hc_addsub_vl
  import spec_hc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SPEC_WIN = SPEC_WIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_corrected
`ifdef SPEC_HC_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic             accept;
  logic             use_fix;

  logic [WIDTH-1:0] spec_sum, exact_sum;
  logic             spec_cout, exact_cout, err;
  logic [WIDTH:0]   spec_c, exact_c;

  spec_hc_core #(
    .WIDTH    (WIDTH),
    .SPEC_WIN (SPEC_WIN)
  ) u_core (
    .a          (a_q),
    .b_eff      (b_q),
    .cin_eff    (cin_q),
    .spec_sum   (spec_sum),
    .spec_cout  (spec_cout),
    .exact_sum  (exact_sum),
    .exact_cout (exact_cout),
    .spec_c     (spec_c),
    .exact_c    (exact_c),
    .err        (err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b ^ {WIDTH{in_sub}};
      cin_q <= in_sub | in_cin;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    use_fix   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = EVAL;
      end
      EVAL: begin
        if (err) begin
          state_nxt = FIX;
        end else begin
          out_valid = 1'b1;
          if (out_ready) state_nxt = accept ? EVAL : IDLE;
        end
      end
      FIX: begin
        out_valid = 1'b1;
        use_fix   = 1'b1;
        if (out_ready) state_nxt = accept ? EVAL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational through out_ready so a draining result frees the slot in the same cycle.
  assign in_ready = (state == IDLE) | (out_valid & out_ready);
  assign accept   = in_valid & in_ready;

  assign out_sum       = use_fix ? exact_sum  : spec_sum;
  assign out_cout      = use_fix ? exact_cout : spec_cout;
  assign out_ovf       = use_fix ? (exact_c[WIDTH-1] ^ exact_c[WIDTH])
                                 : (spec_c[WIDTH-1] ^ spec_c[WIDTH]);
  assign out_corrected = use_fix;

`ifdef SPEC_HC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (state == EVAL && err && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spec_hc_addsub_vl.sv
// Self-checking bench for spec_hc_addsub_vl: directed vector table, hand sequences, random scoreboard.
module tb_spec_hc_addsub_vl;

  localparam int W   = 16;
  localparam int WIN = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_sub, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf, out_corrected;
`ifdef SPEC_HC_ERR_CNT_EN
  logic [15:0]  err_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spec_hc_addsub_vl #(.WIDTH(W), .SPEC_WIN(WIN)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_sub        (in_sub),
    .in_cin        (in_cin),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_cout      (out_cout),
    .out_ovf       (out_ovf),
    .out_corrected (out_corrected)
`ifdef SPEC_HC_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         err;
  } res_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] sum;
    logic         cout, ovf, corr;
  } vec_t;

  // Exact result by plain integer arithmetic; speculation error by summing each bit's window.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    res_t            r;
    logic [W-1:0]    be, ssum;
    logic [W:0]      sc;
    longint unsigned av, bv, ce, full, ws, m;
    int              lo, n;
    be   = sub ? ~b : b;
    ce   = (sub || cin) ? 64'd1 : 64'd0;
    av   = a;
    bv   = be;
    full = av + bv + ce;
    sc   = '0;
    sc[0] = (ce != 0);
    for (int i = 1; i <= W; i++) begin
      lo = (i > WIN) ? i - WIN : 0;
      n  = i - lo;
      m  = (64'd1 << n) - 64'd1;
      ws = ((av >> lo) & m) + ((bv >> lo) & m) + ((i <= WIN) ? ce : 64'd0);
      sc[i] = (((ws >> n) & 64'd1) != 0);
    end
    ssum   = a ^ be ^ sc[W-1:0];
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
    r.err  = ({sc[W], ssum} != {r.cout, r.sum});
    return r;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[10];
  logic [W-1:0] sa[8], sb[8];

  task automatic run_stream(output int last_cyc);
    int   idx, nd, cyc;
    res_t e;
    idx = 0; nd = 0; cyc = 0; last_cyc = -1;
    out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
    while (nd < 8 && cyc < 40) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_a = sa[idx];
        in_b = sb[idx];
      end
      #3;
      if (out_valid) begin
        e = model(sa[nd], sb[nd], 1'b0, 1'b0);
        chk("stream_sum", out_sum, e.sum);
        chk("stream_corr", out_corrected, e.err);
        nd++;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_all_delivered", nd, 8);
  endtask

  initial begin
    int           lat, last;
    res_t         e;
    res_t         q[$];
    logic [31:0]  r32;
    logic         acc_prev, hold_prev, hold_corr;
    logic [W-1:0] hold_sum;
    int           mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (2) step;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_corr", out_corrected, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
`ifdef SPEC_HC_ERR_CNT_EN
    chk("rst_err_count", err_count, 0);
`endif

    vecs[0] = '{16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hABCD, 16'h0000, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h01FF, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_a = vecs[k].a; in_b = vecs[k].b; in_sub = vecs[k].sub; in_cin = vecs[k].cin;
      in_valid = 1'b1;
      #1;
      chk("tbl_in_ready", in_ready, 1);
      step;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 6) begin
        step;
        lat++;
      end
      chk("tbl_latency", lat, vecs[k].corr ? 2 : 1);
      chk("tbl_sum", out_sum, vecs[k].sum);
      chk("tbl_cout", out_cout, vecs[k].cout);
      chk("tbl_ovf", out_ovf, vecs[k].ovf);
      chk("tbl_corr", out_corrected, vecs[k].corr);
      step;
    end

    // Backpressure: result must hold and the offered op must not be taken.
    in_a = 16'h1234; in_b = 16'h0101; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step;
    in_a = 16'h4444; in_b = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", out_sum, 16'h1335);
      chk("bp_in_ready", in_ready, 0);
      step;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step;
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_sum", out_sum, 16'h5555);
    step;

    for (int k = 0; k < 8; k++) begin
      sa[k] = {8'(k + 1), 8'(k + 1)};
      sb[k] = 16'h0011;
    end
    run_stream(last);
    chk("stream_cycles_noerr", last, 8);
    sa[3] = 16'hFFFF;
    sb[3] = 16'h0001;
    run_stream(last);
    chk("stream_cycles_one_err", last, 9);

    // Reset while the correction is being offered.
    in_a = 16'hFFFF; in_b = 16'h0001; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("rstfix_eval_valid", out_valid, 0);
    step;
    chk("rstfix_fix_corr", out_corrected, 1);
`ifdef SPEC_HC_ERR_CNT_EN
    chk("rstfix_count_nonzero", (err_count != 0), 1);
`endif
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rstfix_valid", out_valid, 0);
    chk("rstfix_in_ready", in_ready, 1);
    chk("rstfix_sum", out_sum, 0);
    chk("rstfix_corr", out_corrected, 0);
`ifdef SPEC_HC_ERR_CNT_EN
    chk("rstfix_err_count", err_count, 0);
`endif

    // Random traffic against the scoreboard, with random backpressure.
    acc_prev = 1'b0; hold_prev = 1'b0; hold_sum = '0; hold_corr = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid || acc_prev) begin
        in_valid = (cyc < 380) && ($urandom_range(0, 3) != 0);
        mode = $urandom_range(0, 3);
        r32 = $urandom; in_a = r32[W-1:0];
        r32 = $urandom; in_b = r32[W-1:0];
        r32 = $urandom; in_sub = r32[0]; in_cin = r32[1];
        case (mode)
          1: begin in_b = ~in_a; in_sub = 1'b0; end
          2: begin in_b = in_a;  in_sub = 1'b1; end
          3: begin in_a = 16'hFFFF >> $urandom_range(0, 15); in_b = 16'h0001; in_sub = 1'b0; end
          default: ;
        endcase
      end
      out_ready = ($urandom_range(0, 3) != 0) || (cyc >= 380);
      #3;
      if (hold_prev) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_sum", out_sum, hold_sum);
        chk("rnd_hold_corr", out_corrected, hold_corr);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_valid", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_sum", out_sum, e.sum);
          chk("rnd_cout", out_cout, e.cout);
          chk("rnd_ovf", out_ovf, e.ovf);
          chk("rnd_corr", out_corrected, e.err);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_sum  = out_sum;
      hold_corr = out_corrected;
      acc_prev  = in_valid && in_ready;
      if (acc_prev) q.push_back(model(in_a, in_b, in_sub, in_cin));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      #3;
      if (out_valid) begin
        e = q.pop_front();
        chk("rnd_drain_sum", out_sum, e.sum);
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
